mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle MIPS control unit sitting directly upstream of the ALU in the MCCPU datapath.
- Decodes the latched instruction's Op/Funct and sequences the FETCH/DECODE/EXEC/MEM/WB states.
- Drives the ALU's ALUOp plus all datapath enables and mux selects.
- Consumes the ALU Zero flag to resolve branches.

Parameters:
- OP_W, 6, opcode field width.
- FN_W, 6, funct field width.
- ALUOP_W, 4, ALUOp width (matches ALU).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Op  in  6  IR[31:26]; stable from end of FETCH.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU Zero flag (combinational, same cycle).
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  GPR write enable.
- MemWrite  out  1  data memory write enable.
- EXTOp  out  1  1=sign-extend imm16, 0=zero-extend.
- ALUOp  out  4  ALU operation code.
- ASel  out  1  ALU A: 0=rs, 1=shamt.
- BSel  out  1  ALU B: 0=rt, 1=extended imm.
- NPCOp  out  2  00 PC+4, 01 branch, 10 jump, 11 jr.
- GPRSel  out  2  write register: 00 rd, 01 rt, 10 $31.
- WDSel  out  2  write data: 00 ALUOut, 01 MDR, 10 PC.
- Illegal  out  1  illegal-instruction flag (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high. State forced to S_FETCH. All outputs are forced to 0 while rst=1. First FETCH executes on the first rising edge after rst falls. Reset mid-instruction abandons it; no partial writes occur after rst rises.
- Outputs are a Moore decode of state, qualified by Op/Funct. Only PCWrite in S_BRANCH depends on Zero. Default for every output in every state is 0 unless listed below.
- ALUOp codes: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, NOR 0111, LUI 1000, SLL 1001, SRL 1010, SLLV 1011, SRLV 1100.
- S_FETCH: IRWrite=1, PCWrite=1, NPCOp=00. Next state S_DECODE.
- S_DECODE: no writes. Next state by opcode:
  - R-ALU or I-ALU -> S_EXEC.
  - lw/sw -> S_MEMADR.
  - beq/bne -> S_BRANCH.
  - j/jal, or R-type jr/jalr -> S_JUMP.
  - Anything else -> S_FETCH (illegal; no state updated).
- S_EXEC: drives ALUOp, ASel, BSel, EXTOp. Next state S_ALUWB.
  - R-type funct map: addu->ADD, subu->SUB, and, or, nor, slt, sltu, sll (ASel=1), srl (ASel=1), sllv, srlv.
  - I-type: addi->ADD with EXTOp=1; andi/ori with EXTOp=0; slti->SLT with EXTOp=1; lui->LUI.
- S_ALUWB: RegWrite=1, WDSel=00. GPRSel=00 for R-type, 01 for I-type. Next state S_FETCH.
- S_MEMADR: ALUOp=ADD, BSel=1, EXTOp=1. Next state S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD: read only. Next state S_MEMWB.
- S_MEMWB: RegWrite=1, WDSel=01, GPRSel=01. Next state S_FETCH.
- S_MEMWR: MemWrite=1. Next state S_FETCH.
- S_BRANCH: ALUOp=SUB, BSel=0, NPCOp=01. PCWrite=Zero for beq, ~Zero for bne. Next state S_FETCH.
- S_JUMP: PCWrite=1. Next state S_FETCH.
  - NPCOp=10 for j/jal, 11 for jr/jalr.
  - jal: RegWrite=1, GPRSel=10, WDSel=10.
  - jalr: RegWrite=1, GPRSel=00, WDSel=10.
- Cycle counts: R/I-ALU 4, lw 5, sw 4, branch 3, jump 3, illegal 2.
- Enable exclusivity: MemWrite and RegWrite are never both 1. IRWrite is only ever 1 in S_FETCH.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an undefined opcode/funct in S_DECODE moves to S_HALT and sets Illegal=1 (sticky). S_HALT has all enables 0 and is left only by rst.
- Undefined: the illegal case returns to S_FETCH (acts as NOP); Illegal is tied to 0.

Decomposition:
- Shared header mips_ctrl_def.v holds:
  - opcode and funct constants;
  - state encodings (4-bit);
  - NPCOp, GPRSel and WDSel codes.
- ALUOp codes stay in ctrl_encode_def.v, shared with the ALU.
- One sub-module: mc_alu_dec, combinational Op/Funct -> {ALUOp, ASel, BSel, EXTOp}, used in S_EXEC and S_MEMADR.

Test Plan:
- addu $3,$1,$2 (Op=0, Funct=0x21) -> exactly 4 cycles:
  - FETCH: IRWrite=PCWrite=1;
  - EXEC: ALUOp=0001, BSel=0;
  - ALUWB: RegWrite=1, GPRSel=00.
- lw (Op=0x23) -> 5 cycles: MEMADR ALUOp=0001, BSel=1, EXTOp=1; MEMWB RegWrite=1, WDSel=01, GPRSel=01. sw (Op=0x2B) -> MemWrite=1 for exactly 1 cycle.
- beq with Zero=1 -> PCWrite=1, NPCOp=01 in S_BRANCH. bne with Zero=1 -> PCWrite=0. Both back to FETCH after 3 cycles.
- sll (Funct=0x00) -> ASel=1, ALUOp=1001. ori (Op=0x0D) -> EXTOp=0, ALUOp=0100, GPRSel=01. jal (Op=0x03) -> PCWrite=1, NPCOp=10, GPRSel=10, WDSel=10.
- Op=0x3F:
  - with ILLEGAL_TRAP_EN: Illegal=1 stays set, no enables for 10 cycles until rst;
  - without it: returns to FETCH, no writes.
- Assert rst during S_MEMWR -> MemWrite falls immediately (asynchronous). After release, first cycle is FETCH with IRWrite=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - opcode / funct constants for the supported instruction subset
//   - FSM state encoding (4-bit)
//   - ALUOp codes (shared with the ALU)
//   - NPCOp, GPRSel and WDSel mux codes
//   - classify(): groups an Op/Funct pair into the path the FSM follows
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALUOp codes
    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SLLV = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b1100;

    // Next-PC select
    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    // Destination register select
    localparam logic [1:0] GPR_RD = 2'b00;
    localparam logic [1:0] GPR_RT = 2'b01;
    localparam logic [1:0] GPR_31 = 2'b10;

    // Write-back data select
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MDR = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        IC_ALU,
        IC_MEM,
        IC_BRANCH,
        IC_JUMP,
        IC_ILLEGAL
    } instr_class_t;

    // Anything not listed here is an undefined instruction.
    function automatic instr_class_t classify(input logic [5:0] op, input logic [5:0] funct);
        instr_class_t ic;
        ic = IC_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU,
                    FN_SLL, FN_SRL, FN_SLLV, FN_SRLV: ic = IC_ALU;
                    FN_JR, FN_JALR:                   ic = IC_JUMP;
                    default:                          ic = IC_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: ic = IC_ALU;
            OP_LW, OP_SW:                              ic = IC_MEM;
            OP_BEQ, OP_BNE:                            ic = IC_BRANCH;
            OP_J, OP_JAL:                              ic = IC_JUMP;
            default:                                   ic = IC_ILLEGAL;
        endcase
        return ic;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU-control decoder.
//   Maps the latched Op/Funct onto the ALU-side controls. The FSM only
//   forwards these in S_EXEC and S_MEMADR.
// Ports:
//   op, funct  in   instruction fields
//   alu_op     out  ALUOp code
//   a_sel      out  ALU A source (1 = shamt, used by sll/srl)
//   b_sel      out  ALU B source (1 = extended imm16)
//   ext_op     out  1 = sign-extend imm16, 0 = zero-extend
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       a_sel,
    output logic       b_sel,
    output logic       ext_op
);

    always_comb begin
        alu_op = ALU_NOP;
        a_sel  = 1'b0;
        b_sel  = 1'b0;
        ext_op = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL: begin
                        alu_op = ALU_SLL;
                        a_sel  = 1'b1;
                    end
                    FN_SRL: begin
                        alu_op = ALU_SRL;
                        a_sel  = 1'b1;
                    end
                    FN_SLLV: alu_op = ALU_SLLV;
                    FN_SRLV: alu_op = ALU_SRLV;
                    default: alu_op = ALU_NOP;
                endcase
            end
            OP_ADDI: begin
                alu_op = ALU_ADD;
                b_sel  = 1'b1;
                ext_op = 1'b1;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                b_sel  = 1'b1;
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                b_sel  = 1'b1;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT;
                b_sel  = 1'b1;
                ext_op = 1'b1;
            end
            OP_LUI: begin
                alu_op = ALU_LUI;
                b_sel  = 1'b1;
            end
            // Effective address = rs + sign-extended offset
            OP_LW, OP_SW: begin
                alu_op = ALU_ADD;
                b_sel  = 1'b1;
                ext_op = 1'b1;
            end
            default: alu_op = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit (FETCH/DECODE/EXEC/MEM/WB).
//   Moore-style decode of the FSM state qualified by Op/Funct; only PCWrite
//   in S_BRANCH looks at Zero. All outputs are held at 0 while rst is high.
// Build option:
//   ILLEGAL_TRAP_EN  defined: undefined instructions park the FSM in S_HALT
//                    and raise a sticky Illegal flag until rst.
//                    undefined: undefined instructions act as a NOP and
//                    Illegal is tied to 0.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   Op, Funct        latched instruction fields
//   Zero             ALU zero flag
//   PCWrite, IRWrite, RegWrite, MemWrite   datapath enables
//   EXTOp, ALUOp, ASel, BSel               ALU-side controls
//   NPCOp, GPRSel, WDSel                   mux selects
//   Illegal          illegal-instruction flag
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    Op,
    input  logic [FN_W-1:0]    Funct,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ASel,
    output logic               BSel,
    output logic [1:0]         NPCOp,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               Illegal
);

    state_t       state_reg;
    state_t       state_next;
    instr_class_t instr_class;

    logic [3:0] dec_alu_op;
    logic       dec_a_sel;
    logic       dec_b_sel;
    logic       dec_ext_op;

    assign instr_class = classify(Op, Funct);

    mc_alu_dec u_alu_dec (
        .op     (Op),
        .funct  (Funct),
        .alu_op (dec_alu_op),
        .a_sel  (dec_a_sel),
        .b_sel  (dec_b_sel),
        .ext_op (dec_ext_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == S_DECODE && instr_class == IC_ILLEGAL) begin
            illegal_reg <= 1'b1;
        end
    end

    assign Illegal = illegal_reg;
`else
    assign Illegal = 1'b0;
`endif

    // Outputs are gated by rst directly so that a reset mid-instruction
    // (e.g. during S_MEMWR) drops every enable without waiting for a clock.
    always_comb begin
        state_next = state_reg;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        EXTOp      = 1'b0;
        ALUOp      = ALU_NOP;
        ASel       = 1'b0;
        BSel       = 1'b0;
        NPCOp      = NPC_PC4;
        GPRSel     = GPR_RD;
        WDSel      = WD_ALU;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    NPCOp      = NPC_PC4;
                    state_next = S_DECODE;
                end
                S_DECODE: begin
                    case (instr_class)
                        IC_ALU:    state_next = S_EXEC;
                        IC_MEM:    state_next = S_MEMADR;
                        IC_BRANCH: state_next = S_BRANCH;
                        IC_JUMP:   state_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                        default:   state_next = S_HALT;
`else
                        default:   state_next = S_FETCH;
`endif
                    endcase
                end
                S_EXEC: begin
                    ALUOp      = dec_alu_op;
                    ASel       = dec_a_sel;
                    BSel       = dec_b_sel;
                    EXTOp      = dec_ext_op;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    WDSel      = WD_ALU;
                    GPRSel     = (Op == OP_RTYPE) ? GPR_RD : GPR_RT;
                    state_next = S_FETCH;
                end
                S_MEMADR: begin
                    ALUOp      = dec_alu_op;
                    ASel       = dec_a_sel;
                    BSel       = dec_b_sel;
                    EXTOp      = dec_ext_op;
                    state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    WDSel      = WD_MDR;
                    GPRSel     = GPR_RT;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    ALUOp      = ALU_SUB;
                    BSel       = 1'b0;
                    NPCOp      = NPC_BRANCH;
                    PCWrite    = (Op == OP_BEQ) ? Zero : ~Zero;
                    state_next = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    if (Op == OP_RTYPE) begin
                        NPCOp = NPC_JR;
                        if (Funct == FN_JALR) begin
                            RegWrite = 1'b1;
                            GPRSel   = GPR_RD;
                            WDSel    = WD_PC;
                        end
                    end else begin
                        NPCOp = NPC_JUMP;
                        if (Op == OP_JAL) begin
                            RegWrite = 1'b1;
                            GPRSel   = GPR_31;
                            WDSel    = WD_PC;
                        end
                    end
                    state_next = S_FETCH;
                end
                // Trap sink: every output stays 0 until rst.
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl.
//   The reference model describes each instruction as a fixed list of
//   per-cycle output vectors indexed by cycle number within the instruction.
//   Op/Funct carry random garbage during the FETCH cycle (IR not yet loaded).
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ASel, BSel, Illegal;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, GPRSel, WDSel;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .EXTOp    (EXTOp),
        .ALUOp    (ALUOp),
        .ASel     (ASel),
        .BSel     (BSel),
        .NPCOp    (NPCOp),
        .GPRSel   (GPRSel),
        .WDSel    (WDSel),
        .Illegal  (Illegal)
    );

    // {PCWrite,IRWrite,RegWrite,MemWrite,EXTOp,ALUOp[3:0],ASel,BSel,NPCOp,GPRSel,WDSel,Illegal}
    logic [17:0] obs;
    assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUOp, ASel, BSel,
                  NPCOp, GPRSel, WDSel, Illegal};

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    typedef enum {K_RALU, K_IALU, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;

    localparam logic [5:0] R_FUNCTS [13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A,
                                              6'h2B, 6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h09};
    localparam logic [5:0] I_OPS [11] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23,
                                           6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    localparam logic [5:0] BAD_OPS [4] = '{6'h3F, 6'h01, 6'h10, 6'h20};

    function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h08 || fn == 6'h09) return K_J;
            for (int i = 0; i < 11; i++) if (R_FUNCTS[i] == fn) return K_RALU;
            return K_ILL;
        end
        case (op)
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return K_IALU;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04, 6'h05: return K_BR;
            6'h02, 6'h03: return K_J;
            default: return K_ILL;
        endcase
    endfunction

    // Instruction length in cycles; a trapped illegal is observed for
    // DECODE + 10 halted cycles.
    function automatic int n_cycles(input kind_t k);
        case (k)
            K_RALU, K_IALU, K_SW: return 4;
            K_LW:                 return 5;
            K_BR, K_J:            return 3;
`ifdef ILLEGAL_TRAP_EN
            default:              return 12;
`else
            default:              return 2;
`endif
        endcase
    endfunction

    function automatic logic [17:0] expect_out(input logic [5:0] op, input logic [5:0] fn,
                                               input int cyc, input logic z);
        logic pcw, irw, rw, mw, ext, asel, bsel, ill;
        logic [3:0] alu;
        logic [1:0] npc, gsel, wd;
        kind_t k;
        pcw = 0; irw = 0; rw = 0; mw = 0; ext = 0; asel = 0; bsel = 0; ill = 0;
        alu = 4'd0; npc = 2'd0; gsel = 2'd0; wd = 2'd0;
        k = kind_of(op, fn);
        if (cyc == 0) begin
            pcw = 1; irw = 1;
        end else if (cyc >= 2) begin
            case (k)
                K_RALU: begin
                    if (cyc == 2) begin
                        case (fn)
                            6'h21: alu = 4'd1;
                            6'h23: alu = 4'd2;
                            6'h24: alu = 4'd3;
                            6'h25: alu = 4'd4;
                            6'h27: alu = 4'd7;
                            6'h2A: alu = 4'd5;
                            6'h2B: alu = 4'd6;
                            6'h00: begin alu = 4'd9;  asel = 1; end
                            6'h02: begin alu = 4'd10; asel = 1; end
                            6'h04: alu = 4'd11;
                            default: alu = 4'd12;
                        endcase
                    end else begin
                        rw = 1; gsel = 2'd0;
                    end
                end
                K_IALU: begin
                    if (cyc == 2) begin
                        bsel = 1;
                        case (op)
                            6'h08: begin alu = 4'd1; ext = 1; end
                            6'h0C: alu = 4'd3;
                            6'h0D: alu = 4'd4;
                            6'h0A: begin alu = 4'd5; ext = 1; end
                            default: alu = 4'd8;
                        endcase
                    end else begin
                        rw = 1; gsel = 2'd1;
                    end
                end
                K_LW: begin
                    if (cyc == 2) begin alu = 4'd1; bsel = 1; ext = 1; end
                    if (cyc == 4) begin rw = 1; wd = 2'd1; gsel = 2'd1; end
                end
                K_SW: begin
                    if (cyc == 2) begin alu = 4'd1; bsel = 1; ext = 1; end
                    if (cyc == 3) mw = 1;
                end
                K_BR: begin
                    alu = 4'd2; npc = 2'd1;
                    pcw = (op == 6'h04) ? z : ~z;
                end
                K_J: begin
                    pcw = 1;
                    if (op == 6'h00) begin
                        npc = 2'd3;
                        if (fn == 6'h09) begin rw = 1; gsel = 2'd0; wd = 2'd2; end
                    end else begin
                        npc = 2'd2;
                        if (op == 6'h03) begin rw = 1; gsel = 2'd2; wd = 2'd2; end
                    end
                end
                default: ill = 1;
            endcase
        end
        return {pcw, irw, rw, mw, ext, alu, asel, bsel, npc, gsel, wd, ill};
    endfunction

    // zmode: 0/1 force Zero, 2 random. abort_at: cycle after which rst is
    // asserted asynchronously (-1 = none).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int abort_at);
        int n;
        logic [17:0] e;
        n = n_cycles(kind_of(op, fn));
`ifdef ILLEGAL_TRAP_EN
        if (kind_of(op, fn) == K_ILL) abort_at = n - 1;
`endif
        $display("instr op=%02h funct=%02h cycles=%0d abort_at=%0d", op, fn, n, abort_at);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            if (c == 0) begin
                Op    = 6'($urandom);
                Funct = 6'($urandom);
            end else begin
                Op    = op;
                Funct = fn;
            end
            Zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            @(negedge clk);
            e = expect_out(op, fn, c, Zero);
            check($sformatf("op%02h_f%02h_c%0d", op, fn, c), obs, e);
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1 check("rst_async", obs, 18'd0);
                @(negedge clk);
                check("rst_hold", obs, 18'd0);
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] op, fn;
        int r;
        rst = 1'b1; Op = 6'h00; Funct = 6'h21; Zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", obs, 18'd0);
        Op = 6'h2B; Zero = 1'b1;
        @(negedge clk);
        check("reset_outputs_op", obs, 18'd0);

        // Directed cases
        run_instr(6'h00, 6'h21, 2, -1);   // addu
        run_instr(6'h23, 6'h00, 2, -1);   // lw
        run_instr(6'h2B, 6'h00, 2, -1);   // sw
        run_instr(6'h04, 6'h00, 1, -1);   // beq taken
        run_instr(6'h05, 6'h00, 1, -1);   // bne not taken
        run_instr(6'h04, 6'h00, 0, -1);   // beq not taken
        run_instr(6'h05, 6'h00, 0, -1);   // bne taken
        run_instr(6'h00, 6'h00, 2, -1);   // sll
        run_instr(6'h0D, 6'h15, 2, -1);   // ori
        run_instr(6'h03, 6'h00, 2, -1);   // jal
        run_instr(6'h00, 6'h08, 2, -1);   // jr
        run_instr(6'h00, 6'h09, 2, -1);   // jalr
        run_instr(6'h3F, 6'h00, 2, -1);   // undefined opcode
        run_instr(6'h00, 6'h21, 2, -1);
        run_instr(6'h2B, 6'h00, 2, 3);    // reset during S_MEMWR
        run_instr(6'h00, 6'h21, 2, -1);   // first instruction after reset
        run_instr(6'h23, 6'h00, 2, 2);    // reset during S_MEMADR

        // Random instruction stream
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                op = 6'h00;
                fn = R_FUNCTS[$urandom_range(0, 12)];
            end else if (r < 9) begin
                op = I_OPS[$urandom_range(0, 10)];
                fn = 6'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                op = BAD_OPS[$urandom_range(0, 3)];
                fn = 6'($urandom);
            end else begin
                op = 6'h00;
                fn = 6'h3F;
            end
            run_instr(op, fn, 2, ($urandom_range(0, 19) == 0) ? 2 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
